// File: rtl/locker_ctrl.sv
// locker_ctrl: keypad sequencing controller for the digital locker.
// Assembles 4-digit entries, checks them against the stored password,
// drives unlock, runs the change-password sequence and the failed-attempt
// lockout. Optional macro LOCKER_INACTIVITY_TIMEOUT_EN adds an inactivity
// abort while an entry is being collected.
module locker_ctrl #(
   parameter logic [15:0] DEFAULT_PW     = 16'h0000,
   parameter int          MAX_FAILS      = 3,
   parameter int          OPEN_CYCLES    = 8,
   parameter int          LOCKOUT_CYCLES = 16,
   parameter int          TIMEOUT_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  digit,
   input  logic        digit_valid,
   input  logic        set_req,
   input  logic        clear,
   input  logic        relock,
   output logic        unlock,
   output logic        locked_out,
   output logic        err,
   output logic        pw_updated,
   output logic [3:0]  fail_cnt,
   output logic [15:0] stored_pw
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ENTRY     = 3'd1;
   localparam logic [2:0] S_CHECK     = 3'd2;
   localparam logic [2:0] S_NEW_ENTRY = 3'd3;
   localparam logic [2:0] S_COMMIT    = 3'd4;
   localparam logic [2:0] S_OPEN      = 3'd5;
   localparam logic [2:0] S_LOCKOUT   = 3'd6;

   // One down-counter serves both OPEN and LOCKOUT; size it for the longer.
   localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   logic [2:0]    state;
   logic          set_mode;
   logic [15:0]   entry;
   logic [1:0]    cnt;
   logic [TW-1:0] timer;
   logic          collecting;
   logic          timeout_hit;

   assign unlock     = (state == S_OPEN);
   assign locked_out = (state == S_LOCKOUT);
   assign collecting = (state == S_ENTRY) || (state == S_NEW_ENTRY);

`ifdef LOCKER_INACTIVITY_TIMEOUT_EN
   localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
   logic [OW-1:0] idle_cnt;

   assign timeout_hit = collecting && !digit_valid &&
                        (idle_cnt == OW'(TIMEOUT_CYCLES - 1));

   // Count consecutive cycles without a digit while an entry is open.
   always_ff @(posedge clk) begin
      if (rst)
         idle_cnt <= '0;
      else if (collecting && !digit_valid && !timeout_hit)
         idle_cnt <= idle_cnt + 1'b1;
      else
         idle_cnt <= '0;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Main sequencer: state, entry assembly, fail counter and stored password.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         set_mode   <= 1'b0;
         entry      <= '0;
         cnt        <= '0;
         timer      <= '0;
         fail_cnt   <= '0;
         err        <= 1'b0;
         pw_updated <= 1'b0;
         stored_pw  <= DEFAULT_PW;
      end else begin
         err        <= 1'b0;
         pw_updated <= 1'b0;
         case (state)
            S_IDLE: begin
               entry <= '0;
               cnt   <= '0;
               if (digit_valid) begin
                  set_mode <= set_req;
                  entry    <= {digit, 12'h000};
                  cnt      <= 2'd1;
                  state    <= S_ENTRY;
               end
            end
            S_ENTRY, S_NEW_ENTRY: begin
               if (clear || timeout_hit) begin
                  // Abort: discard the partial entry, fail count untouched.
                  err   <= 1'b1;
                  entry <= '0;
                  cnt   <= '0;
                  state <= S_IDLE;
               end else if (digit_valid) begin
                  case (cnt)
                     2'd0:    entry[15:12] <= digit;
                     2'd1:    entry[11:8]  <= digit;
                     2'd2:    entry[7:4]   <= digit;
                     default: entry[3:0]   <= digit;
                  endcase
                  if (cnt == 2'd3)
                     state <= (state == S_ENTRY) ? S_CHECK : S_COMMIT;
                  else
                     cnt <= cnt + 2'd1;
               end
            end
            S_CHECK: begin
               if (entry == stored_pw) begin
                  fail_cnt <= '0;
                  if (set_mode) begin
                     entry <= '0;
                     cnt   <= '0;
                     state <= S_NEW_ENTRY;
                  end else begin
                     timer <= TW'(OPEN_CYCLES - 1);
                     state <= S_OPEN;
                  end
               end else begin
                  err      <= 1'b1;
                  fail_cnt <= fail_cnt + 4'd1;
                  entry    <= '0;
                  cnt      <= '0;
                  if ((fail_cnt + 4'd1) == 4'(MAX_FAILS)) begin
                     timer <= TW'(LOCKOUT_CYCLES - 1);
                     state <= S_LOCKOUT;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_COMMIT: begin
               stored_pw  <= entry;
               pw_updated <= 1'b1;
               entry      <= '0;
               cnt        <= '0;
               state      <= S_IDLE;
            end
            S_OPEN: begin
               entry <= '0;
               cnt   <= '0;
               if (relock || timer == '0)
                  state <= S_IDLE;
               else
                  timer <= timer - 1'b1;
            end
            S_LOCKOUT: begin
               entry <= '0;
               cnt   <= '0;
               if (timer == '0) begin
                  fail_cnt <= '0;
                  state    <= S_IDLE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: begin
               entry <= '0;
               cnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_locker_ctrl.sv
// tb_locker_ctrl: directed scoreboard bench for locker_ctrl (DEFAULT_PW=16'h1234).
// Expectations are queued as stimulus is applied and popped when the
// corresponding DUT behaviour has been observed.
module tb_locker_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  digit;
   logic        digit_valid;
   logic        set_req;
   logic        clear;
   logic        relock;
   logic        unlock;
   logic        locked_out;
   logic        err;
   logic        pw_updated;
   logic [3:0]  fail_cnt;
   logic [15:0] stored_pw;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   locker_ctrl #(
      .DEFAULT_PW(16'h1234),
      .MAX_FAILS(3),
      .OPEN_CYCLES(8),
      .LOCKOUT_CYCLES(16),
      .TIMEOUT_CYCLES(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .digit(digit),
      .digit_valid(digit_valid),
      .set_req(set_req),
      .clear(clear),
      .relock(relock),
      .unlock(unlock),
      .locked_out(locked_out),
      .err(err),
      .pw_updated(pw_updated),
      .fail_cnt(fail_cnt),
      .stored_pw(stored_pw)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t e;
      compared++;
      if (sb.size() == 0) begin
         mismatched++;
         $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic send_digit(input logic [3:0] d, input logic s);
      digit       = d;
      set_req     = s;
      digit_valid = 1'b1;
      tick();
      digit_valid = 1'b0;
      set_req     = 1'b0;
   endtask

   task automatic send_code(input logic [15:0] c, input logic s);
      send_digit(c[15:12], s);
      send_digit(c[11:8], 1'b0);
      send_digit(c[7:4], 1'b0);
      send_digit(c[3:0], 1'b0);
   endtask

   // Run n cycles, optionally strobing digits on the first dig_ticks cycles,
   // and tally what the outputs did.
   task automatic window(input int n, input int dig_ticks,
                         output int unl, output int errc, output int pwc,
                         output int lko, output int first_unl, output int first_err);
      unl = 0; errc = 0; pwc = 0; lko = 0; first_unl = -1; first_err = -1;
      for (int i = 1; i <= n; i++) begin
         digit       = 4'h1;
         digit_valid = (i <= dig_ticks);
         tick();
         if (unlock) begin
            unl++;
            if (first_unl < 0) first_unl = i;
         end
         if (err) begin
            errc++;
            if (first_err < 0) first_err = i;
         end
         if (pw_updated) pwc++;
         if (locked_out) lko++;
      end
      digit_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unl, errc, pwc, lko, fu, fe;
      rst = 1'b1; digit = '0; digit_valid = 1'b0; set_req = 1'b0;
      clear = 1'b0; relock = 1'b0;

      // Reset state
      expect_val("rst_unlock", 0);
      expect_val("rst_locked_out", 0);
      expect_val("rst_err", 0);
      expect_val("rst_pw_updated", 0);
      expect_val("rst_fail_cnt", 0);
      expect_val("rst_stored_pw", 32'h1234);
      do_reset();
      observe(unlock); observe(locked_out); observe(err);
      observe(pw_updated); observe(fail_cnt); observe(stored_pw);
      $display("txn reset: stored_pw=%h fail_cnt=%0d", stored_pw, fail_cnt);

      // Correct code opens for exactly 8 cycles, one cycle after CHECK
      send_code(16'h1234, 1'b0);
      expect_val("open_count", 8);
      expect_val("open_latency", 1);
      expect_val("open_err", 0);
      window(20, 0, unl, errc, pwc, lko, fu, fe);
      observe(unl); observe(fu); observe(errc);
      expect_val("open_fail_cnt", 0);
      expect_val("open_stored_pw", 32'h1234);
      observe(fail_cnt); observe(stored_pw);
      $display("txn unlock 1234: unlock_cycles=%0d first=%0d", unl, fu);

      // Three wrong codes -> lockout
      for (int k = 1; k <= 2; k++) begin
         send_code(16'h1235, 1'b0);
         expect_val("bad_err", 1);
         expect_val("bad_unlock", 0);
         window(4, 0, unl, errc, pwc, lko, fu, fe);
         observe(errc); observe(unl);
         expect_val("bad_fail_cnt", k);
         observe(fail_cnt);
         $display("txn wrong code #%0d: err_pulses=%0d fail_cnt=%0d", k, errc, fail_cnt);
      end
      send_code(16'h1235, 1'b0);
      tick();
      expect_val("lock_err", 1);
      expect_val("lock_fail_cnt", 3);
      expect_val("lock_enter", 1);
      observe(err); observe(fail_cnt); observe(locked_out);
      expect_val("lock_remaining", 15);
      expect_val("lock_unlock", 0);
      window(24, 8, unl, errc, pwc, lko, fu, fe);
      observe(lko); observe(unl);
      expect_val("lock_exit_fail_cnt", 0);
      observe(fail_cnt);
      $display("txn lockout: locked_cycles=%0d fail_cnt=%0d", lko + 1, fail_cnt);
      send_code(16'h1234, 1'b0);
      expect_val("post_lock_open", 8);
      window(12, 0, unl, errc, pwc, lko, fu, fe);
      observe(unl);
      $display("txn unlock after lockout: unlock_cycles=%0d", unl);

      // Change password 1234 -> 9876
      send_code(16'h1234, 1'b1);
      tick(); tick();
      send_code(16'h9876, 1'b0);
      expect_val("set_pw_updated", 1);
      expect_val("set_unlock", 0);
      window(4, 0, unl, errc, pwc, lko, fu, fe);
      observe(pwc); observe(unl);
      expect_val("set_stored_pw", 32'h9876);
      observe(stored_pw);
      $display("txn change pw: pw_updated=%0d stored_pw=%h", pwc, stored_pw);
      send_code(16'h1234, 1'b0);
      expect_val("old_pw_err", 1);
      window(4, 0, unl, errc, pwc, lko, fu, fe);
      observe(errc);
      send_code(16'h9876, 1'b0);
      expect_val("new_pw_open", 8);
      window(12, 0, unl, errc, pwc, lko, fu, fe);
      observe(unl);
      $display("txn new pw 9876: unlock_cycles=%0d", unl);

      // clear together with a digit aborts; fail count kept
      do_reset();
      send_code(16'h1111, 1'b0);
      window(3, 0, unl, errc, pwc, lko, fu, fe);
      send_digit(4'h1, 1'b0);
      send_digit(4'h2, 1'b0);
      clear = 1'b1; digit = 4'h3; digit_valid = 1'b1;
      tick();
      clear = 1'b0; digit_valid = 1'b0;
      expect_val("clear_err", 1);
      expect_val("clear_fail_cnt", 1);
      observe(err); observe(fail_cnt);
      tick();
      send_code(16'h1234, 1'b0);
      expect_val("clear_then_open", 8);
      window(12, 0, unl, errc, pwc, lko, fu, fe);
      observe(unl);
      $display("txn clear abort: fail_cnt=%0d then unlock_cycles=%0d", fail_cnt, unl);

      // Relock on the third OPEN cycle
      send_code(16'h1234, 1'b0);
      tick(); tick(); tick();
      relock = 1'b1;
      expect_val("relock_before", 1);
      observe(unlock);
      tick();
      relock = 1'b0;
      expect_val("relock_after", 0);
      observe(unlock);
      $display("txn relock: unlock=%0d after relock", unlock);

      // Reset during NEW_ENTRY restores default password
      tick();
      send_code(16'h1234, 1'b1);
      tick(); tick();
      send_code(16'h5555, 1'b0);
      window(3, 0, unl, errc, pwc, lko, fu, fe);
      send_code(16'h5555, 1'b1);
      tick(); tick();
      send_digit(4'h1, 1'b0);
      send_digit(4'h1, 1'b0);
      expect_val("midrst_pw_before", 32'h5555);
      observe(stored_pw);
      rst = 1'b1;
      digit = 4'h1; digit_valid = 1'b1;
      tick();
      rst = 1'b0; digit_valid = 1'b0;
      expect_val("midrst_stored_pw", 32'h1234);
      expect_val("midrst_outputs", 0);
      observe(stored_pw);
      observe({unlock, locked_out, err, pw_updated, fail_cnt});
      $display("txn reset in NEW_ENTRY: stored_pw=%h", stored_pw);
      tick();
      send_code(16'h1234, 1'b0);
      expect_val("midrst_open", 8);
      window(12, 0, unl, errc, pwc, lko, fu, fe);
      observe(unl);

      // Inactivity: one digit then a long idle stretch
      send_digit(4'h1, 1'b0);
`ifdef LOCKER_INACTIVITY_TIMEOUT_EN
      expect_val("timeout_err", 1);
      expect_val("timeout_at", 32);
`else
      expect_val("timeout_err", 0);
      expect_val("timeout_at", 32'hFFFF_FFFF);
`endif
      window(40, 0, unl, errc, pwc, lko, fu, fe);
      observe(errc); observe(fe);
      send_digit(4'h2, 1'b0);
      send_digit(4'h3, 1'b0);
      send_digit(4'h4, 1'b0);
`ifdef LOCKER_INACTIVITY_TIMEOUT_EN
      expect_val("timeout_resume", 0);
`else
      expect_val("timeout_resume", 8);
`endif
      window(12, 0, unl, errc, pwc, lko, fu, fe);
      observe(unl);
      $display("txn inactivity: unlock_cycles after resume=%0d", unl);

      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
